// File: rtl/neo_stream_mc.sv
// Streaming multi-channel k-spaced Nonlinear Energy Operator.
// psi[n] = x[n]^2 - x[n-K]*x[n+K] per channel, computed when x[n+K] arrives,
// with per-channel history, warm-up gating, optional clipping and a spike flag.
module neo_stream_mc #(
  parameter int unsigned N  = 16,
  parameter int unsigned K  = 1,
  parameter int unsigned C  = 2,
  parameter int unsigned OW = 2*N+1,
  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        in_ch,
  input  logic signed [N-1:0]  in_data,
  input  logic signed [OW-1:0] thr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_ch,
  output logic signed [OW-1:0] out_data,
  output logic                 out_sat,
  output logic                 out_spike
);

  localparam int unsigned D    = 2*K+1;        // window length
  localparam int unsigned HD   = 2*K;          // stored taps (oldest tap falls out on the shift)
  localparam int unsigned CN   = 1 << CW;      // array depth covering every in_ch code
  localparam int unsigned PW   = 2*N;
  localparam int unsigned DW   = 2*N+1;
  localparam int unsigned CNTW = $clog2(D+1);

  // hist[c][0] is the newest stored sample; after a shift the new sample becomes h[0],
  // so the post-shift h[2K] is the pre-shift h[2K-1] and only 2K taps need storage.
  logic signed [N-1:0]  hist [CN][HD];
  logic [CNTW-1:0]      cnt  [CN];

  logic                 accept;
  logic                 ch_ok;
  logic                 take;
  logic                 qualify;
  logic signed [N-1:0]  centre;
  logic signed [N-1:0]  left;
  logic signed [PW-1:0] sq;
  logic signed [PW-1:0] lr;
  logic signed [DW-1:0] diff;
  logic signed [OW-1:0] res_c;
  logic                 sat_c;
  logic                 spike_c;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign ch_ok    = 32'(in_ch) < C;
  assign take     = accept && ch_ok && !clear;
  // Counter including this sample reaches 2K+1 exactly when the stored count is >= 2K.
  assign qualify  = take && (cnt[in_ch] >= CNTW'(HD));

  // Post-shift window taps read from pre-shift history; right tap is the incoming sample.
  assign centre = hist[in_ch][K-1];
  assign left   = hist[in_ch][HD-1];
  assign sq     = PW'(centre) * PW'(centre);
  assign lr     = PW'(left) * PW'(in_data);
  assign diff   = DW'(sq) - DW'(lr);

  generate
    if (OW >= DW) begin : g_wide
      assign res_c = OW'(diff);
      assign sat_c = 1'b0;
    end else begin : g_clip
      logic hi_ones;
      logic hi_zeros;
      // Clip when the discarded high bits are not a pure sign extension.
      assign hi_ones  = &diff[DW-1:OW-1];
      assign hi_zeros = ~|diff[DW-1:OW-1];
      assign sat_c    = !(hi_ones || hi_zeros);
      assign res_c    = sat_c ? (diff[DW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}})
                              : diff[OW-1:0];
    end
  endgenerate

  assign spike_c = res_c > thr;

  // Per-channel history shift and saturating warm-up counter.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < CN; c++) begin
        cnt[c] <= '0;
        for (int unsigned t = 0; t < HD; t++) hist[c][t] <= '0;
      end
    end else if (clear) begin
      for (int unsigned c = 0; c < CN; c++) begin
        cnt[c] <= '0;
        for (int unsigned t = 0; t < HD; t++) hist[c][t] <= '0;
      end
    end else if (take) begin
      hist[in_ch][0] <= in_data;
      for (int unsigned t = 1; t < HD; t++) hist[in_ch][t] <= hist[in_ch][t-1];
      if (cnt[in_ch] < CNTW'(D)) cnt[in_ch] <= cnt[in_ch] + CNTW'(1);
    end
  end

  // Single output register: load on qualifying accept, hold under backpressure, drop on pop.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_spike <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (qualify) begin
      out_valid <= 1'b1;
      out_ch    <= in_ch;
      out_data  <= res_c;
      out_sat   <= sat_c;
      out_spike <= spike_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neo_stream_mc.sv
// Self-checking bench: instance a (K=1, C=2, full width) and instance b (K=2, C=1, OW=16).
module tb_neo_stream_mc;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic reset;
  logic clear_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_sat_a, out_spike_a;
  logic [0:0] in_ch_a, out_ch_a;
  logic signed [15:0] in_data_a;
  logic signed [32:0] thr_a, out_data_a;
  logic clear_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_sat_b, out_spike_b;
  logic [0:0] in_ch_b, out_ch_b;
  logic signed [15:0] in_data_b, thr_b, out_data_b;

  neo_stream_mc #(.N(16), .K(1), .C(2), .OW(33)) u_a (
    .Clk(Clk), .reset(reset), .clear(clear_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_ch(in_ch_a), .in_data(in_data_a), .thr(thr_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_ch(out_ch_a), .out_data(out_data_a), .out_sat(out_sat_a),
    .out_spike(out_spike_a));

  neo_stream_mc #(.N(16), .K(2), .C(1), .OW(16)) u_b (
    .Clk(Clk), .reset(reset), .clear(clear_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_ch(in_ch_b), .in_data(in_data_b), .thr(thr_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_ch(out_ch_b), .out_data(out_data_b), .out_sat(out_sat_b),
    .out_spike(out_spike_b));

  typedef struct {
    int     ch;
    longint data;
    bit     sat;
    bit     spike;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   win_a0[$];
  int   win_a1[$];
  int   win_b[$];
  int   checks = 0;
  int   errors = 0;

  // Reference psi over a full window (index 0 oldest), clipped to ow bits.
  function automatic exp_t calc(input int w[$], input int k, input int ow, input int ch,
                                input longint th);
    exp_t   e;
    longint p;
    longint lim;
    p     = longint'(w[k]) * longint'(w[k]) - longint'(w[0]) * longint'(w[2*k]);
    lim   = longint'(1) << (ow - 1);
    e.sat = 1'b0;
    if (p > lim - 1) begin
      p = lim - 1; e.sat = 1'b1;
    end else if (p < -lim) begin
      p = -lim; e.sat = 1'b1;
    end
    e.ch    = ch;
    e.data  = p;
    e.spike = (p > th);
    return e;
  endfunction

  task automatic model_a(input int ch, input int d, input longint th);
    if (ch == 0) begin
      win_a0.push_back(d);
      if (win_a0.size() > 3) void'(win_a0.pop_front());
      if (win_a0.size() == 3) exp_a.push_back(calc(win_a0, 1, 33, 0, th));
    end else begin
      win_a1.push_back(d);
      if (win_a1.size() > 3) void'(win_a1.pop_front());
      if (win_a1.size() == 3) exp_a.push_back(calc(win_a1, 1, 33, 1, th));
    end
  endtask

  task automatic model_b(input int ch, input int d, input longint th);
    if (ch == 0) begin
      win_b.push_back(d);
      if (win_b.size() > 5) void'(win_b.pop_front());
      if (win_b.size() == 5) exp_b.push_back(calc(win_b, 2, 16, 0, th));
    end
  endtask

  // Scoreboard a: every negedge with valid && ready is one transfer at the next edge.
  always @(negedge Clk) begin : mon_a
    exp_t e;
    if (reset && out_valid_a && out_ready_a) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL sb_a unexpected output ch=%0d data=%0d, none required", out_ch_a, out_data_a);
      end else begin
        e = exp_a.pop_front();
        if (out_ch_a !== 1'(e.ch) || out_data_a !== 33'(e.data) || out_sat_a !== e.sat ||
            out_spike_a !== e.spike) begin
          errors++;
          $display("FAIL sb_a got ch=%0d data=%0d sat=%0b spike=%0b required ch=%0d data=%0d sat=%0b spike=%0b",
                   out_ch_a, out_data_a, out_sat_a, out_spike_a, e.ch, e.data, e.sat, e.spike);
        end
      end
    end
  end

  // Scoreboard b.
  always @(negedge Clk) begin : mon_b
    exp_t e;
    if (reset && out_valid_b && out_ready_b) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL sb_b unexpected output data=%0d, none required", out_data_b);
      end else begin
        e = exp_b.pop_front();
        if (out_ch_b !== 1'(e.ch) || out_data_b !== 16'(e.data) || out_sat_b !== e.sat ||
            out_spike_b !== e.spike) begin
          errors++;
          $display("FAIL sb_b got ch=%0d data=%0d sat=%0b spike=%0b required ch=%0d data=%0d sat=%0b spike=%0b",
                   out_ch_b, out_data_b, out_sat_b, out_spike_b, e.ch, e.data, e.sat, e.spike);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic send_a(input int ch, input int d, input longint th);
    bit got;
    got = 1'b0;
    in_valid_a = 1'b1; in_ch_a = 1'(ch); in_data_a = 16'(d); thr_a = 33'(th);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge Clk);
      if (in_ready_a) begin
        got = 1'b1;
        model_a(ch, d, th);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_a timeout in_ready=%0b required 1", in_ready_a);
    end
    step();
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input int ch, input int d, input longint th);
    bit got;
    got = 1'b0;
    in_valid_b = 1'b1; in_ch_b = 1'(ch); in_data_b = 16'(d); thr_b = 16'(th);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge Clk);
      if (in_ready_b) begin
        got = 1'b1;
        model_b(ch, d, th);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_b timeout in_ready=%0b required 1", in_ready_b);
    end
    step();
    in_valid_b = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_a = 1'b0; in_valid_a = 1'b0; in_ch_a = '0; in_data_a = '0; thr_a = '0; out_ready_a = 1'b0;
    clear_b = 1'b0; in_valid_b = 1'b0; in_ch_b = '0; in_data_b = '0; thr_b = '0; out_ready_b = 1'b0;
    #2 reset = 1'b0;
    @(negedge Clk);
    checks++;
    if ({out_valid_a, out_ch_a, out_data_a, out_sat_a, out_spike_a} !== '0) begin
      errors++;
      $display("FAIL reset_a valid=%0b ch=%0d data=%0d sat=%0b spike=%0b required all 0",
               out_valid_a, out_ch_a, out_data_a, out_sat_a, out_spike_a);
    end
    checks++;
    if ({out_valid_b, out_ch_b, out_data_b, out_sat_b, out_spike_b} !== '0) begin
      errors++;
      $display("FAIL reset_b valid=%0b ch=%0d data=%0d sat=%0b spike=%0b required all 0",
               out_valid_b, out_ch_b, out_data_b, out_sat_b, out_spike_b);
    end
    step();
    reset = 1'b1;
    @(negedge Clk);
    checks++;
    if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got a=%0b b=%0b required 1 1", in_ready_a, in_ready_b);
    end
    step();
  endtask

  task automatic test_basic();
    int  ds[3]  = '{3, 5, 7};
    out_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_a(0, ds[i], 0);
      @(negedge Clk);
      checks++;
      if (out_valid_a !== (i == 2) ||
          (i == 2 && (out_data_a !== 33'sd4 || out_ch_a !== 1'b0 || out_sat_a !== 1'b0 || out_spike_a !== 1'b1))) begin
        errors++;
        $display("FAIL basic_%0d valid=%0b data=%0d ch=%0d required valid=%0b data=4 ch=0",
                 i, out_valid_a, out_data_a, out_ch_a, i == 2);
      end
      step();
    end
  endtask

  task automatic test_interleave();
    int chs[6] = '{0, 1, 0, 1, 0, 1};
    int ds[6]  = '{1, 10, 2, 10, 4, 10};
    clear_a = 1'b1;
    step();
    clear_a = 1'b0;
    win_a0.delete(); win_a1.delete();
    for (int i = 0; i < 6; i++) begin
      send_a(chs[i], ds[i], -1);
      @(negedge Clk);
      checks++;
      if (out_valid_a !== (i >= 4) ||
          (i >= 4 && (out_ch_a !== 1'(chs[i]) || out_data_a !== 33'sd0))) begin
        errors++;
        $display("FAIL interleave_%0d valid=%0b ch=%0d data=%0d required valid=%0b ch=%0d data=0",
                 i, out_valid_a, out_ch_a, out_data_a, i >= 4, chs[i]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    out_ready_a = 1'b0;
    send_a(1, 20, -200);
    in_valid_a = 1'b1; in_ch_a = 1'b1; in_data_a = 16'sd30; thr_a = 33'sd100;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checks++;
      if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || out_data_a !== -33'sd100 ||
          out_spike_a !== 1'b1 || out_ch_a !== 1'b1) begin
        errors++;
        $display("FAIL stall_%0d in_ready=%0b valid=%0b data=%0d spike=%0b required 0 1 -100 1",
                 i, in_ready_a, out_valid_a, out_data_a, out_spike_a);
      end
      step();
    end
    out_ready_a = 1'b1;
    @(negedge Clk);
    checks++;
    if (in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL release in_ready=%0b required 1", in_ready_a);
    end else begin
      model_a(1, 30, 100);
    end
    step();
    in_valid_a = 1'b0;
    @(negedge Clk);
    checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 33'sd100 || out_spike_a !== 1'b0) begin
      errors++;
      $display("FAIL after_release valid=%0b data=%0d spike=%0b required 1 100 0",
               out_valid_a, out_data_a, out_spike_a);
    end
    step();
  endtask

  task automatic test_ramp_b();
    out_ready_b = 1'b1;
    for (int n = 0; n < 10; n++) begin
      send_b(0, n, 3);
      if (n == 3 || n == 4) begin
        @(negedge Clk);
        checks++;
        if (out_valid_b !== (n == 4) ||
            (n == 4 && (out_data_b !== 16'sd4 || out_sat_b !== 1'b0 || out_spike_b !== 1'b1))) begin
          errors++;
          $display("FAIL ramp_%0d valid=%0b data=%0d sat=%0b spike=%0b required valid=%0b data=4 sat=0 spike=1",
                   n, out_valid_b, out_data_b, out_sat_b, out_spike_b, n == 4);
        end
        step();
      end
    end
    repeat (2) step();
  endtask

  task automatic test_saturation_b();
    int pos[5] = '{-32768, 0, -32768, 0, 32767};
    int neg[5] = '{32767, 1, 0, 1, 32767};
    for (int i = 0; i < 5; i++) send_b(0, pos[i], 0);
    @(negedge Clk);
    checks++;
    if (out_valid_b !== 1'b1 || out_data_b !== 16'sd32767 || out_sat_b !== 1'b1 || out_spike_b !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos valid=%0b data=%0d sat=%0b spike=%0b required 1 32767 1 1",
               out_valid_b, out_data_b, out_sat_b, out_spike_b);
    end
    step();
    for (int i = 0; i < 5; i++) send_b(0, neg[i], 0);
    @(negedge Clk);
    checks++;
    if (out_valid_b !== 1'b1 || out_data_b !== -16'sd32768 || out_sat_b !== 1'b1 || out_spike_b !== 1'b0) begin
      errors++;
      $display("FAIL sat_neg valid=%0b data=%0d sat=%0b spike=%0b required 1 -32768 1 0",
               out_valid_b, out_data_b, out_sat_b, out_spike_b);
    end
    step();
  endtask

  task automatic test_bad_channel_b();
    send_b(0, 5, 0);
    send_b(1, 999, 0);
    @(negedge Clk);
    checks++;
    if (out_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL bad_ch_drop valid=%0b required 0", out_valid_b);
    end
    step();
    send_b(0, 6, 0);
    @(negedge Clk);
    checks++;
    if (out_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL bad_ch_next valid=%0b required 1", out_valid_b);
    end
    step();
  endtask

  task automatic test_clear();
    out_ready_a = 1'b1;
    send_a(0, 5, 0);
    out_ready_a = 1'b0;
    clear_a = 1'b1;
    step();
    clear_a = 1'b0;
    exp_a.delete(); win_a0.delete(); win_a1.delete();
    @(negedge Clk);
    checks++;
    if (out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL clear_valid valid=%0b required 0", out_valid_a);
    end
    step();
    out_ready_a = 1'b1;
    in_valid_a = 1'b1; in_ch_a = 1'b0; in_data_a = 16'sd100; clear_a = 1'b1;
    @(negedge Clk);
    checks++;
    if (in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL clear_drop_ready in_ready=%0b required 1", in_ready_a);
    end
    step();
    clear_a = 1'b0; in_valid_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_a(0, i + 1, 0);
      @(negedge Clk);
      checks++;
      if (out_valid_a !== (i == 2)) begin
        errors++;
        $display("FAIL clear_warm_%0d valid=%0b required %0b", i, out_valid_a, i == 2);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    send_a(0, 4, 0);
    send_b(0, 7, 0);
    out_ready_a = 1'b0; out_ready_b = 1'b0;
    reset = 1'b0;
    exp_a.delete(); exp_b.delete(); win_a0.delete(); win_a1.delete(); win_b.delete();
    @(negedge Clk);
    checks++;
    if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL midreset_valid a=%0b b=%0b required 0 0", out_valid_a, out_valid_b);
    end
    step();
    reset = 1'b1; out_ready_a = 1'b1; out_ready_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_a(1, 2 * i - 3, 0);
      @(negedge Clk);
      checks++;
      if (out_valid_a !== (i == 2)) begin
        errors++;
        $display("FAIL midreset_a_%0d valid=%0b required %0b", i, out_valid_a, i == 2);
      end
      step();
    end
    for (int i = 0; i < 5; i++) begin
      send_b(0, 100 * i - 150, -10);
      if (i >= 3) begin
        @(negedge Clk);
        checks++;
        if (out_valid_b !== (i == 4)) begin
          errors++;
          $display("FAIL midreset_b_%0d valid=%0b required %0b", i, out_valid_b, i == 4);
        end
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleave();
    test_backpressure();
    test_ramp_b();
    test_saturation_b();
    test_bad_channel_b();
    test_clear();
    test_reset_mid();
    repeat (3) step();
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL leftover pending a=%0d b=%0d required 0 0", exp_a.size(), exp_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
